// File: rtl/cfi_pkg.sv
// Shared types and encodings for the forward-edge CFI landing-pad checker.
package cfi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ELP,
        ST_CHK_M,
        ST_CHK_U,
        ST_FAULT
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_NO_LP = 3'd1,
        CAUSE_LBL_L = 3'd2,
        CAUSE_LBL_M = 3'd3,
        CAUSE_LBL_U = 3'd4
    } cause_e;

    typedef struct packed {
        logic [7:0] upper;
        logic [7:0] middle;
        logic [8:0] lower;
    } label_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [2:0] F3_CFI     = 3'b100;
    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [6:0] IMM_LL     = 7'b1000001;
    localparam logic [6:0] IMM_MU     = 7'b1000011;

    typedef struct packed {
        logic       is_ind_jump;
        logic       is_lpcll;
        logic       is_lpsll;
        logic       is_sml;
        logic       is_cml;
        logic       is_sul;
        logic       is_cul;
        logic [8:0] imm_label;
    } cls_t;

    // x1/x5 are the link registers; jumps through them with rd=x0 are returns.
    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/cfi_instr_classify.sv
// Combinational decode of a committed instruction into CFI classification flags.
module cfi_instr_classify
    import cfi_pkg::*;
#(
    parameter int CHECK_COMPRESSED = 1
) (
    input  logic [31:0] i_instr,
    input  logic        i_compressed,
    output cls_t        o_cls
);

    logic w_cfi;
    logic w_ll;
    logic w_mu;
    logic w_jalr;
    logic w_cjump;

    assign w_cfi = !i_compressed && (i_instr[6:0] == OPC_OP_IMM) &&
                   (i_instr[14:12] == F3_CFI) && (i_instr[11:7] == 5'd0);
    assign w_ll  = w_cfi && (i_instr[31:25] == IMM_LL);
    assign w_mu  = w_cfi && (i_instr[31:25] == IMM_MU);

    assign w_jalr = !i_compressed && (i_instr[6:0] == OPC_JALR) &&
                    (i_instr[14:12] == F3_JALR) &&
                    !((i_instr[11:7] == 5'd0) && is_link_reg(i_instr[19:15]));

    // C.JR (bit12=0) / C.JALR (bit12=1); only C.JR through a link register is a return.
    assign w_cjump = i_compressed && (i_instr[1:0] == 2'b10) &&
                     (i_instr[15:13] == 3'b100) && (i_instr[11:7] != 5'd0) &&
                     (i_instr[6:2] == 5'd0) &&
                     !(!i_instr[12] && is_link_reg(i_instr[11:7]));

    always_comb begin
        o_cls             = '0;
        o_cls.is_ind_jump = w_jalr || ((CHECK_COMPRESSED != 0) && w_cjump);
        o_cls.is_lpcll    = w_ll && i_instr[24];
        o_cls.is_lpsll    = w_ll && !i_instr[24];
        o_cls.is_sml      = w_mu && !i_instr[24] && !i_instr[23];
        o_cls.is_cml      = w_mu && !i_instr[24] && i_instr[23];
        o_cls.is_sul      = w_mu && i_instr[24] && !i_instr[23];
        o_cls.is_cul      = w_mu && i_instr[24] && i_instr[23];
        o_cls.imm_label   = i_instr[23:15];
    end

endmodule

// File: rtl/cfi_lp_checker.sv
// Landing-pad checker: tracks the expected-landing-pad state after indirect jumps
// and latches a fault when the target does not start with a matching label check.
module cfi_lp_checker
    import cfi_pkg::*;
#(
    parameter int XLEN             = 64,
    parameter int CHECK_COMPRESSED = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            lp_en_i,
    input  logic            flush_i,
    input  logic            commit_valid_i,
    input  logic [31:0]     commit_instr_i,
    input  logic            commit_compressed_i,
    input  logic [XLEN-1:0] commit_pc_i,
    input  logic            fault_ack_i,
    output logic            fault_o,
    output logic [2:0]      fault_cause_o,
    output logic [XLEN-1:0] fault_pc_o,
    output logic            elp_o,
    output logic [24:0]     label_o
);

    cls_t            w_cls;
    state_e          r_state;
    state_e          w_state_nxt;
    cause_e          w_cause_nxt;
    label_t          r_label;
    logic            r_fault;
    cause_e          r_cause;
    logic [XLEN-1:0] r_fault_pc;
    logic            r_elp;
    logic            w_l_match;
    logic            w_m_match;
    logic            w_u_match;
    logic            w_label_wr;

    cfi_instr_classify #(
        .CHECK_COMPRESSED(CHECK_COMPRESSED)
    ) u_classify (
        .i_instr     (commit_instr_i),
        .i_compressed(commit_compressed_i),
        .o_cls       (w_cls)
    );

    assign w_l_match  = (w_cls.imm_label == r_label.lower);
    assign w_m_match  = (w_cls.imm_label[7:0] == r_label.middle);
    assign w_u_match  = (w_cls.imm_label[7:0] == r_label.upper);
    assign w_label_wr = commit_valid_i && !flush_i && (r_state != ST_FAULT);

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = CAUSE_NONE;
        if (r_state == ST_FAULT) begin
            if (fault_ack_i) w_state_nxt = ST_IDLE;
        end else if (flush_i || !lp_en_i) begin
            w_state_nxt = ST_IDLE;
        end else if (commit_valid_i) begin
            case (r_state)
                ST_ELP: begin
                    if (w_cls.is_lpcll && w_l_match) begin
                        w_state_nxt = ST_CHK_M;
                    end else begin
                        w_state_nxt = ST_FAULT;
                        w_cause_nxt = w_cls.is_lpcll ? CAUSE_LBL_L : CAUSE_NO_LP;
                    end
                end
                ST_CHK_M: begin
                    if (w_cls.is_cml) begin
                        w_state_nxt = w_m_match ? ST_CHK_U : ST_FAULT;
                        w_cause_nxt = w_m_match ? CAUSE_NONE : CAUSE_LBL_M;
                    end else if (w_cls.is_cul) begin
                        w_state_nxt = w_u_match ? ST_IDLE : ST_FAULT;
                        w_cause_nxt = w_u_match ? CAUSE_NONE : CAUSE_LBL_U;
                    end else begin
                        w_state_nxt = w_cls.is_ind_jump ? ST_ELP : ST_IDLE;
                    end
                end
                ST_CHK_U: begin
                    if (w_cls.is_cul) begin
                        w_state_nxt = w_u_match ? ST_IDLE : ST_FAULT;
                        w_cause_nxt = w_u_match ? CAUSE_NONE : CAUSE_LBL_U;
                    end else begin
                        w_state_nxt = w_cls.is_ind_jump ? ST_ELP : ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = w_cls.is_ind_jump ? ST_ELP : ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_elp      <= 1'b0;
            r_fault    <= 1'b0;
            r_cause    <= CAUSE_NONE;
            r_fault_pc <= '0;
            r_label    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_elp   <= (w_state_nxt == ST_ELP);
            if ((r_state != ST_FAULT) && (w_state_nxt == ST_FAULT)) begin
                r_fault    <= 1'b1;
                r_cause    <= w_cause_nxt;
                r_fault_pc <= commit_pc_i;
            end else if ((r_state == ST_FAULT) && (w_state_nxt != ST_FAULT)) begin
                r_fault    <= 1'b0;
                r_cause    <= CAUSE_NONE;
                r_fault_pc <= '0;
            end
            // Label writes land even when the same commit raises NO_LP.
            if (w_label_wr && w_cls.is_lpsll) r_label.lower  <= w_cls.imm_label;
            if (w_label_wr && w_cls.is_sml)   r_label.middle <= w_cls.imm_label[7:0];
            if (w_label_wr && w_cls.is_sul)   r_label.upper  <= w_cls.imm_label[7:0];
        end
    end

    assign fault_o       = r_fault;
    assign fault_cause_o = r_cause;
    assign fault_pc_o    = r_fault_pc;
    assign elp_o         = r_elp;
    assign label_o       = r_label;

endmodule

// File: tb/tb_cfi_lp_checker.sv
// Directed self-checking bench for cfi_lp_checker.
module tb_cfi_lp_checker;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lp_en_i;
    logic        flush_i;
    logic        commit_valid_i;
    logic [31:0] commit_instr_i;
    logic        commit_compressed_i;
    logic [63:0] commit_pc_i;
    logic        fault_ack_i;
    logic        fault_o;
    logic [2:0]  fault_cause_o;
    logic [63:0] fault_pc_o;
    logic        elp_o;
    logic [24:0] label_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] ADDI = 32'h0000_0013;

    cfi_lp_checker #(.XLEN(64), .CHECK_COMPRESSED(1)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .lp_en_i            (lp_en_i),
        .flush_i            (flush_i),
        .commit_valid_i     (commit_valid_i),
        .commit_instr_i     (commit_instr_i),
        .commit_compressed_i(commit_compressed_i),
        .commit_pc_i        (commit_pc_i),
        .fault_ack_i        (fault_ack_i),
        .fault_o            (fault_o),
        .fault_cause_o      (fault_cause_o),
        .fault_pc_o         (fault_pc_o),
        .elp_o              (elp_o),
        .label_o            (label_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] enc_ll(input logic chk, input logic [8:0] lbl);
        return {7'b1000001, chk, lbl, 3'b100, 5'd0, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_mu(input logic up, input logic chk, input logic [7:0] lbl);
        return {7'b1000011, up, chk, lbl, 3'b100, 5'd0, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rs1);
        return {12'd0, rs1, 3'b000, 5'd0, 7'b1100111};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic commit(input logic [31:0] ins, input logic comp, input logic [63:0] pc);
        commit_valid_i      = 1'b1;
        commit_instr_i      = ins;
        commit_compressed_i = comp;
        commit_pc_i         = pc;
        @(posedge clk_i);
        #1;
        commit_valid_i      = 1'b0;
        commit_compressed_i = 1'b0;
    endtask

    task automatic ack();
        fault_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        fault_ack_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; lp_en_i = 1'b1; flush_i = 1'b0; fault_ack_i = 1'b0;
        commit_valid_i = 1'b0; commit_instr_i = '0; commit_compressed_i = 1'b0; commit_pc_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_fault", 64'(fault_o), 64'd0);
        chk("rst_cause", 64'(fault_cause_o), 64'd0);
        chk("rst_pc", fault_pc_o, 64'd0);
        chk("rst_elp", 64'(elp_o), 64'd0);
        chk("rst_label", 64'(label_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Matching landing pad
        commit(enc_ll(1'b0, 9'h1A5), 1'b0, 64'h1000);
        chk("t1_label", 64'(label_o), 64'h1A5);
        chk("t1_elp_before", 64'(elp_o), 64'd0);
        commit(enc_jalr(5'd10), 1'b0, 64'h1004);
        chk("t1_elp_after_jalr", 64'(elp_o), 64'd1);
        commit(enc_ll(1'b1, 9'h1A5), 1'b0, 64'h2000);
        chk("t1_elp_after_lpcll", 64'(elp_o), 64'd0);
        chk("t1_no_fault", 64'(fault_o), 64'd0);
        commit(ADDI, 1'b0, 64'h2004);
        chk("t1_no_fault_idle", 64'(fault_o), 64'd0);

        // Lower label mismatch
        commit(enc_ll(1'b0, 9'h1A5), 1'b0, 64'h2008);
        commit(enc_jalr(5'd10), 1'b0, 64'h200C);
        commit(enc_ll(1'b1, 9'h0A5), 1'b0, 64'h8000_0040);
        chk("t2_fault", 64'(fault_o), 64'd1);
        chk("t2_cause", 64'(fault_cause_o), 64'd2);
        chk("t2_pc", fault_pc_o, 64'h8000_0040);
        commit(enc_jalr(5'd10), 1'b0, 64'h8000_0044);
        commit(enc_ll(1'b0, 9'h0FF), 1'b0, 64'h8000_0048);
        commit(ADDI, 1'b0, 64'h8000_004C);
        chk("t2_fault_held", 64'(fault_o), 64'd1);
        chk("t2_cause_held", 64'(fault_cause_o), 64'd2);
        chk("t2_pc_held", fault_pc_o, 64'h8000_0040);
        chk("t2_label_frozen", 64'(label_o), 64'h1A5);
        chk("t2_elp_in_fault", 64'(elp_o), 64'd0);
        ack();
        chk("t2_ack_fault", 64'(fault_o), 64'd0);
        chk("t2_ack_cause", 64'(fault_cause_o), 64'd0);
        chk("t2_ack_pc", fault_pc_o, 64'd0);

        // Upper label mismatch after compressed jump
        commit(enc_mu(1'b0, 1'b0, 8'h33), 1'b0, 64'h3000);
        commit(enc_mu(1'b1, 1'b0, 8'h7E), 1'b0, 64'h3002);
        commit(enc_ll(1'b0, 9'h001), 1'b0, 64'h3004);
        chk("t3_label", 64'(label_o), 64'hFC6601);
        commit({16'h0, 16'h9582}, 1'b1, 64'h3008);
        chk("t3_elp_cjalr", 64'(elp_o), 64'd1);
        commit(enc_ll(1'b1, 9'h001), 1'b0, 64'h300A);
        commit(enc_mu(1'b0, 1'b1, 8'h33), 1'b0, 64'h300E);
        chk("t3_no_fault_cml", 64'(fault_o), 64'd0);
        commit(enc_mu(1'b1, 1'b1, 8'h7F), 1'b0, 64'h3012);
        chk("t3_fault", 64'(fault_o), 64'd1);
        chk("t3_cause", 64'(fault_cause_o), 64'd4);
        chk("t3_pc", fault_pc_o, 64'h3012);
        ack();

        // Return is not tracked; non-return jump without landing pad faults
        commit(enc_jalr(5'd1), 1'b0, 64'h4000);
        chk("t4_ret_elp", 64'(elp_o), 64'd0);
        commit(ADDI, 1'b0, 64'h4004);
        chk("t4_ret_no_fault", 64'(fault_o), 64'd0);
        commit(enc_jalr(5'd12), 1'b0, 64'h4008);
        commit(ADDI, 1'b0, 64'h400C);
        chk("t4_fault", 64'(fault_o), 64'd1);
        chk("t4_cause", 64'(fault_cause_o), 64'd1);
        chk("t4_pc", fault_pc_o, 64'h400C);
        ack();

        // Flush abandons the expectation and the same-cycle commit
        commit(enc_jalr(5'd10), 1'b0, 64'h5000);
        chk("t5_elp", 64'(elp_o), 64'd1);
        flush_i = 1'b1;
        commit(enc_ll(1'b0, 9'h0AA), 1'b0, 64'h5004);
        flush_i = 1'b0;
        chk("t5_flush_elp", 64'(elp_o), 64'd0);
        chk("t5_flush_no_fault", 64'(fault_o), 64'd0);
        chk("t5_flush_label", 64'(label_o), 64'hFC6601);
        commit(ADDI, 1'b0, 64'h5008);
        chk("t5_idle_no_fault", 64'(fault_o), 64'd0);

        // Enforcement disabled
        lp_en_i = 1'b0;
        commit(enc_jalr(5'd10), 1'b0, 64'h6000);
        chk("t6_dis_elp", 64'(elp_o), 64'd0);
        commit(ADDI, 1'b0, 64'h6004);
        chk("t6_dis_no_fault", 64'(fault_o), 64'd0);
        commit(enc_mu(1'b1, 1'b0, 8'h55), 1'b0, 64'h6008);
        chk("t6_dis_label", 64'(label_o), 64'hAA6601);
        lp_en_i = 1'b1;
        commit(enc_jalr(5'd10), 1'b0, 64'h600C);
        chk("t6_elp", 64'(elp_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk("t6_arst_elp", 64'(elp_o), 64'd0);
        chk("t6_arst_label", 64'(label_o), 64'd0);
        chk("t6_arst_fault", 64'(fault_o), 64'd0);
        chk("t6_arst_cause", 64'(fault_cause_o), 64'd0);
        chk("t6_arst_pc", fault_pc_o, 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cfi_lp_checker.md
Name: cfi_lp_checker

Overview:
- Forward-edge CFI landing-pad checker, placed downstream of the commit stage on a single commit port.
- Decodes each committed instruction and tracks the expected-landing-pad (ELP) state after indirect jumps.
- Holds the 25-bit label register (upper 8, middle 8, lower 9), which the label-set instructions write.
- Verifies that each indirect-jump target begins with a matching label-check sequence; otherwise raises a latched fault to the CSR/exception logic.

Parameters:
- XLEN, 64, width of commit PC and fault PC.
- CHECK_COMPRESSED, 1, when 1, C.JR/C.JALR (non-return) also arm ELP.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- lp_en_i  in  1  landing-pad enforcement enable (from CSR).
- flush_i  in  1  pipeline flush/trap; abandons pending expectation.
- commit_valid_i  in  1  committed instruction valid this cycle.
- commit_instr_i  in  32  raw instruction word; bits [15:0] only when compressed.
- commit_compressed_i  in  1  instruction is 16-bit.
- commit_pc_i  in  XLEN  PC of committed instruction.
- fault_ack_i  in  1  CSR/exception logic has consumed the fault.
- fault_o  out  1  fault pending (level, held until acknowledged).
- fault_cause_o  out  3  0 none, 1 NO_LP, 2 LBL_L, 3 LBL_M, 4 LBL_U.
- fault_pc_o  out  XLEN  PC of offending instruction.
- elp_o  out  1  high while in ELP state.
- label_o  out  25  current label register {upper, middle, lower}.

Behaviour:
- Reset: state IDLE; label 0; fault_o 0; fault_cause_o 0; fault_pc_o 0; elp_o 0.
- Decode. All CFI forms: opcode OP-IMM, funct3 100, rd x0.
  - imm[11:5]=1000001: bit24=1 is LPCLL (check lower), bit24=0 is LPSLL (set lower). Lower label = bits[23:15].
  - imm[11:5]=1000011: bit24 selects upper(1)/middle(0); bit23 selects check(1)/set(0). Giving SML, CML, SUL, CUL. Label = bits[22:15].
- Indirect jump:
  - JALR, excluding returns (rd=x0 with rs1 x1/x5).
  - C.JR/C.JALR with rs1 != 0, excluding C.JR x1/x5.
- Set instructions write their label field in every state except FAULT, including when lp_en_i=0. The write is visible to the instruction committed the next cycle.
- FSM, advancing only on commit_valid_i:
  - IDLE: indirect jump with lp_en_i → ELP; everything else stays IDLE. Check instructions in IDLE are no-ops.
  - ELP:
    - LPCLL with label match → CHK_M.
    - LPCLL mismatch → FAULT, cause LBL_L.
    - Any other instruction, including set instructions → FAULT, cause NO_LP.
  - CHK_M:
    - CML match → CHK_U; CML mismatch → FAULT, cause LBL_M.
    - CUL match → IDLE; CUL mismatch → FAULT, cause LBL_U.
    - Indirect jump → ELP; other → IDLE.
  - CHK_U:
    - CUL match → IDLE; CUL mismatch → FAULT, cause LBL_U.
    - Indirect jump → ELP; other → IDLE.
  - FAULT: commits ignored. fault_ack_i → IDLE next cycle, and cause/pc clear to 0.
- Latency: a fault on a commit in cycle N appears in cycle N+1. fault_pc_o equals that commit's PC.
- Priority, highest first: rst_i, fault_ack_i (in FAULT only), flush_i, commit.
  - flush_i moves ELP/CHK_M/CHK_U to IDLE, ignores any same-cycle commit, and leaves FAULT and the label unchanged.
- lp_en_i=0 forces the state to IDLE unless in FAULT. A pending fault is still held until acknowledged.
- elp_o is registered and equals (state==ELP).
- fault_ack_i outside FAULT is ignored.

Decomposition:
- Shared package cfi_pkg:
  - state enum {IDLE, ELP, CHK_M, CHK_U, FAULT}.
  - cause enum.
  - label struct {upper[7:0], middle[7:0], lower[8:0]}.
  - CFI opcode/func constants.
  - classification struct {is_ind_jump, is_lpcll, is_lpsll, is_sml, is_cml, is_sul, is_cul, imm_label}.
- One combinational sub-module cfi_instr_classify (instruction in, classification struct out). The checker holds the FSM and registers.

Test Plan:
- LPSLL label 0x1A5, then JALR x0,0(a0), then LPCLL 0x1A5 → no fault; state goes ELP→CHK_M; elp_o high exactly one cycle.
- LPSLL 0x1A5; JALR; LPCLL 0x0A5 at PC 0x8000_0040 → next cycle fault_o=1, cause=2, fault_pc_o=0x8000_0040. Held through 3 further commits; ack → fault_o=0 next cycle.
- SML 0x33, SUL 0x7E, LPSLL 0x001; C.JALR a1; LPCLL 0x001; CML 0x33; CUL 0x7F → cause=4 (LBL_U).
- JALR x0,0(ra) (return) then ADDI → no ELP, no fault. JALR via a2 then ADDI → cause=1 (NO_LP).
- JALR to ELP, then flush_i asserted together with a non-LP commit → IDLE, no fault, label unchanged.
- lp_en_i=0: JALR then ADDI → no fault, elp_o stays 0. SUL 0x55 still updates label_o[24:17]=0x55. Assert rst_i mid-ELP → all outputs 0 immediately.
